// File: rtl/shift_arb.sv
// shift_arb: round-robin arbiter sharing one 4-bit shift register between two requesters.
//   Requester A: the 4-bit word pi_a is loaded into the register, then shifted out on so, MSB first.
//   Requester B: four serial bits on si_b are shifted in and presented as a word on po_b.
//
// Ports:
//   clk             rising-edge clock
//   reset           asynchronous, active-low reset
//   req_a, pi_a     A request level and A parallel data
//   req_b, si_b     B request level and B serial data
//   gnt_a, gnt_b    current owner of the shared register
//   so              serial out; 0 outside SHIFT_OUT
//   po_b            last word captured for B
//   done_a, done_b  one-cycle completion pulses
//   busy            high whenever the FSM is not idle
module shift_arb (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_a,
  input  logic [3:0] pi_a,
  input  logic       req_b,
  input  logic       si_b,
  output logic       gnt_a,
  output logic       gnt_b,
  output logic       so,
  output logic [3:0] po_b,
  output logic       done_a,
  output logic       done_b,
  output logic       busy
);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StShiftOut,
    StShiftIn,
    StDone
  } state_e;

  state_e     state_q;
  logic [3:0] sr_q;
  logic [1:0] cnt_q;
  logic       last_b_q;   // 1: B was granted last (reset value, so A wins the first tie)
  logic       owner_b_q;  // 1: the running transfer belongs to B

  // Serial out is the live register MSB, only while shifting out.
  assign so = (state_q == StShiftOut) & sr_q[3];

  // Grants, done pulses and busy are registered alongside the state they describe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      sr_q      <= 4'd0;
      cnt_q     <= 2'd0;
      last_b_q  <= 1'b1;
      owner_b_q <= 1'b0;
      po_b      <= 4'd0;
      gnt_a     <= 1'b0;
      gnt_b     <= 1'b0;
      done_a    <= 1'b0;
      done_b    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      done_a <= 1'b0;
      done_b <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // On a tie, grant whoever did not go last.
          if (req_a && (!req_b || last_b_q)) begin
            state_q   <= StLoad;
            owner_b_q <= 1'b0;
            last_b_q  <= 1'b0;
            gnt_a     <= 1'b1;
            busy      <= 1'b1;
          end else if (req_b) begin
            state_q   <= StShiftIn;
            owner_b_q <= 1'b1;
            last_b_q  <= 1'b1;
            cnt_q     <= 2'd0;
            gnt_b     <= 1'b1;
            busy      <= 1'b1;
          end
        end
        StLoad: begin
          sr_q    <= pi_a;
          cnt_q   <= 2'd0;
          state_q <= StShiftOut;
        end
        StShiftOut: begin
          sr_q  <= {sr_q[2:0], 1'b0};
          cnt_q <= cnt_q + 2'd1;  // wraps 3->0 as the shift ends
          if (cnt_q == 2'd3) begin
            state_q <= StDone;
            done_a  <= 1'b1;
          end
        end
        StShiftIn: begin
          sr_q  <= {sr_q[2:0], si_b};
          cnt_q <= cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_q <= StDone;
            po_b    <= {sr_q[2:0], si_b};
            done_b  <= 1'b1;
          end
        end
        StDone: begin
          // Always pass through idle, so a still-high request is arbitrated afresh.
          state_q <= StIdle;
          gnt_a   <= 1'b0;
          gnt_b   <= 1'b0;
          busy    <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          gnt_a   <= 1'b0;
          gnt_b   <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  // owner_b_q records the transfer's owner; the grant flops carry the same information.
  logic unused_owner;
  assign unused_owner = owner_b_q;

endmodule

// File: tb/tb_shift_arb.sv
// Directed self-checking bench for shift_arb; inputs driven and outputs sampled on negedge.
module tb_shift_arb;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_a;
  logic [3:0] pi_a;
  logic       req_b;
  logic       si_b;
  logic       gnt_a;
  logic       gnt_b;
  logic       so;
  logic [3:0] po_b;
  logic       done_a;
  logic       done_b;
  logic       busy;

  int total = 0;
  int bad   = 0;

  shift_arb dut (
    .clk    (clk),
    .reset  (reset),
    .req_a  (req_a),
    .pi_a   (pi_a),
    .req_b  (req_b),
    .si_b   (si_b),
    .gnt_a  (gnt_a),
    .gnt_b  (gnt_b),
    .so     (so),
    .po_b   (po_b),
    .done_a (done_a),
    .done_b (done_b),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step();
    reset = 1'b1;
  endtask

  // All outputs packed as {gnt_a, gnt_b, so, done_a, done_b, busy, po_b}.
  function automatic logic [9:0] outs();
    return {gnt_a, gnt_b, so, done_a, done_b, busy, po_b};
  endfunction

  task automatic test_reset();
    reset = 1'b0; req_a = 1'b0; req_b = 1'b0; pi_a = 4'd0; si_b = 1'b0;
    step();
    step();
    total++;
    if (outs() !== 10'd0) begin
      bad++; $display("FAIL reset_outs got=%b exp=%b", outs(), 10'd0);
    end
    reset = 1'b1;
    step();
    total++;
    if (outs() !== 10'd0) begin
      bad++; $display("FAIL reset_idle got=%b exp=%b", outs(), 10'd0);
    end
  endtask

  // A alone, pi_a=1011; req_a dropped after LOAD.
  task automatic test_a_alone();
    logic [3:0] exp_bits;
    exp_bits = 4'b1011;
    req_a = 1'b1; pi_a = 4'b1011;
    step();  // LOAD cycle
    total++;
    if ({gnt_a, gnt_b, busy, so} !== 4'b1010) begin
      bad++; $display("FAIL a_load got=%b exp=1010", {gnt_a, gnt_b, busy, so});
    end
    req_a = 1'b0;
    step();
    pi_a = 4'b0000;  // already sampled; must not disturb the shift
    for (int i = 0; i < 4; i++) begin
      if (i != 0) step();
      total++;
      if ({so, gnt_a, done_a} !== {exp_bits[3-i], 1'b1, 1'b0}) begin
        bad++; $display("FAIL a_so bit%0d got=%b exp=%b", i, {so, gnt_a, done_a},
                        {exp_bits[3-i], 1'b1, 1'b0});
      end
    end
    step();
    total++;
    if ({done_a, done_b, gnt_a, so, busy} !== 5'b10101) begin
      bad++; $display("FAIL a_done got=%b exp=10101", {done_a, done_b, gnt_a, so, busy});
    end
    step();
    total++;
    if ({done_a, gnt_a, busy} !== 3'b000) begin
      bad++; $display("FAIL a_idle got=%b exp=000", {done_a, gnt_a, busy});
    end
  endtask

  // B alone, si_b = 1,1,0,1 -> po_b = 1101, held afterwards.
  task automatic test_b_alone();
    logic [3:0] bits;
    bits = 4'b1101;
    req_b = 1'b1;
    step();  // SHIFT_IN cycle 1
    total++;
    if ({gnt_a, gnt_b, busy} !== 3'b011) begin
      bad++; $display("FAIL b_grant got=%b exp=011", {gnt_a, gnt_b, busy});
    end
    for (int i = 0; i < 4; i++) begin
      si_b = bits[3-i];
      if (i == 3) begin
        total++;
        if (po_b !== 4'b0000) begin
          bad++; $display("FAIL b_po_early got=%b exp=0000", po_b);
        end
      end
      step();
    end
    req_b = 1'b0;
    total++;
    if ({done_b, done_a, gnt_b, po_b} !== 7'b1011101) begin
      bad++; $display("FAIL b_done got=%b exp=1011101", {done_b, done_a, gnt_b, po_b});
    end
    si_b = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if ({busy, done_b, po_b} !== 6'b001101) begin
        bad++; $display("FAIL b_hold c%0d got=%b exp=001101", i, {busy, done_b, po_b});
      end
    end
  endtask

  // Simultaneous requests after reset: A first (0110), then B after one idle cycle.
  task automatic test_simultaneous();
    logic [3:0] exp_bits;
    logic [3:0] b_bits;
    exp_bits = 4'b0110;
    b_bits   = 4'b1001;
    do_reset();
    req_a = 1'b1; req_b = 1'b1; pi_a = 4'b0110;
    step();
    total++;
    if ({gnt_a, gnt_b} !== 2'b10) begin
      bad++; $display("FAIL sim_first got=%b exp=10", {gnt_a, gnt_b});
    end
    req_a = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      total++;
      if ({so, gnt_a, gnt_b} !== {exp_bits[3-i], 2'b10}) begin
        bad++; $display("FAIL sim_so bit%0d got=%b exp=%b", i, {so, gnt_a, gnt_b},
                        {exp_bits[3-i], 2'b10});
      end
    end
    step();
    total++;
    if ({done_a, gnt_b} !== 2'b10) begin
      bad++; $display("FAIL sim_done_a got=%b exp=10", {done_a, gnt_b});
    end
    step();
    total++;
    if ({busy, gnt_a, gnt_b} !== 3'b000) begin
      bad++; $display("FAIL sim_gap got=%b exp=000", {busy, gnt_a, gnt_b});
    end
    step();
    total++;
    if ({gnt_a, gnt_b, busy} !== 3'b011) begin
      bad++; $display("FAIL sim_second got=%b exp=011", {gnt_a, gnt_b, busy});
    end
    req_b = 1'b0;
    for (int i = 0; i < 4; i++) begin
      si_b = b_bits[3-i];
      step();
    end
    total++;
    if ({done_b, po_b} !== 5'b11001) begin
      bad++; $display("FAIL sim_done_b got=%b exp=11001", {done_b, po_b});
    end
    step();
  endtask

  // Both requests held: grants must alternate A,B,A,B and never overlap.
  task automatic test_alternate();
    int   owners[4];
    int   n;
    logic prev_a;
    logic prev_b;
    n = 0; prev_a = 1'b0; prev_b = 1'b0;
    pi_a = 4'b1100; si_b = 1'b1;
    req_a = 1'b1; req_b = 1'b1;
    for (int c = 0; c < 60 && n < 4; c++) begin
      step();
      total++;
      if ((gnt_a & gnt_b) !== 1'b0 || (done_a & done_b) !== 1'b0) begin
        bad++; $display("FAIL alt_overlap c%0d gnt=%b%b done=%b%b exp no overlap",
                        c, gnt_a, gnt_b, done_a, done_b);
      end
      if (gnt_a && !prev_a) begin owners[n] = 0; n++; end
      else if (gnt_b && !prev_b) begin owners[n] = 1; n++; end
      prev_a = gnt_a; prev_b = gnt_b;
    end
    req_a = 1'b0; req_b = 1'b0;
    total++;
    if (n != 4) begin
      bad++; $display("FAIL alt_count got=%0d exp=4", n);
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (owners[i] != (i % 2)) begin
          bad++; $display("FAIL alt_order grant%0d got=%0d exp=%0d", i, owners[i], i % 2);
        end
      end
    end
    for (int c = 0; c < 20 && busy; c++) step();
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL alt_drain busy got=%b exp=0", busy);
    end
  endtask

  // Reset during the second SHIFT_OUT bit aborts silently; transfer restarts from LOAD.
  task automatic test_reset_mid();
    logic [3:0] exp_bits;
    exp_bits = 4'b1101;
    do_reset();
    req_a = 1'b1; pi_a = 4'b1101;
    step();  // LOAD
    step();  // bit 0
    step();  // bit 1
    total++;
    if ({so, gnt_a} !== 2'b11) begin
      bad++; $display("FAIL rm_before got=%b exp=11", {so, gnt_a});
    end
    #1 reset = 1'b0;
    #1;
    total++;
    if (outs() !== 10'd0) begin
      bad++; $display("FAIL rm_async got=%b exp=%b", outs(), 10'd0);
    end
    step();
    step();
    total++;
    if ({done_a, busy} !== 2'b00) begin
      bad++; $display("FAIL rm_nodone got=%b exp=00", {done_a, busy});
    end
    reset = 1'b1;
    step();
    total++;
    if ({gnt_a, busy, so} !== 3'b110) begin
      bad++; $display("FAIL rm_load got=%b exp=110", {gnt_a, busy, so});
    end
    req_a = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      total++;
      if (so !== exp_bits[3-i]) begin
        bad++; $display("FAIL rm_so bit%0d got=%b exp=%b", i, so, exp_bits[3-i]);
      end
    end
    step();
    total++;
    if (done_a !== 1'b1) begin
      bad++; $display("FAIL rm_done got=%b exp=1", done_a);
    end
    step();
  endtask

  // req_b dropped in SHIFT_IN cycle 2; capture still completes with all four bits.
  task automatic test_b_drop();
    logic [3:0] bits;
    bits = 4'b0111;
    req_b = 1'b1;
    step();  // SHIFT_IN cycle 1
    for (int i = 0; i < 4; i++) begin
      if (i == 1) req_b = 1'b0;
      si_b = bits[3-i];
      step();
    end
    total++;
    if ({done_b, gnt_b, po_b} !== 6'b110111) begin
      bad++; $display("FAIL bd_done got=%b exp=110111", {done_b, gnt_b, po_b});
    end
    step();
    step();
    total++;
    if ({busy, done_b, gnt_b, po_b} !== 7'b0000111) begin
      bad++; $display("FAIL bd_idle got=%b exp=0000111", {busy, done_b, gnt_b, po_b});
    end
  endtask

  initial begin
    test_reset();
    test_a_alone();
    test_b_alone();
    test_simultaneous();
    test_alternate();
    test_reset_mid();
    test_b_drop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
